// File: rtl/edge_irq_ctrl.sv
// Per-channel edge interrupt capture: trigger qualification, pending latch, post-clear blanking,
// overrun flags and a combined interrupt line. Define EDGE_IRQ_CNT_EN to add per-channel counters.
module edge_irq_ctrl #(
    parameter int unsigned NCH       = 8,
    parameter int unsigned BLANK_CYC = 4,
    parameter int unsigned CW        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH-1:0]    re_i,
    input  logic [NCH-1:0]    fe_i,
    input  logic [2*NCH-1:0]  mode_i,
    input  logic [NCH-1:0]    clr_i,
    output logic [NCH-1:0]    pend_o,
    output logic [NCH-1:0]    ovr_o,
`ifdef EDGE_IRQ_CNT_EN
    input  logic              cnt_clr_i,
    output logic [CW*NCH-1:0] cnt_o,
`endif
    output logic              irq_o
);

    localparam int unsigned BW = (BLANK_CYC == 0) ? 1 : $clog2(BLANK_CYC + 1);
    localparam logic [BW-1:0] BLoad = (BLANK_CYC == 0) ? '0 : BW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StBlank
    } state_e;

    logic [NCH-1:0] w_trig;
    logic [NCH-1:0] w_pend_nxt;
    logic           r_irq;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic [1:0]    w_mode;
        state_e        r_st;
        logic [BW-1:0] r_bcnt;
        logic          r_pend;
        logic          r_ovr;

        assign w_mode    = mode_i[2*n +: 2];
        assign w_trig[n] = (w_mode[0] & re_i[n]) | (w_mode[1] & fe_i[n]);

        // Next-cycle pending value, shared by the per-channel flag and the combined irq register.
        assign w_pend_nxt[n] = (w_mode != 2'b00) &&
                               (((r_st == StIdle) && w_trig[n]) ||
                                ((r_st == StPend) && (!clr_i[n] || w_trig[n])));

        always_ff @(posedge clk_i) begin
            if (rst_i || (w_mode == 2'b00)) begin
                r_st   <= StIdle;
                r_bcnt <= '0;
                r_ovr  <= 1'b0;
                r_pend <= 1'b0;
            end else begin
                r_pend <= w_pend_nxt[n];
                unique case (r_st)
                    StIdle: begin
                        if (clr_i[n]) r_ovr <= 1'b0;
                        if (w_trig[n]) r_st <= StPend;
                    end
                    StPend: begin
                        if (clr_i[n]) begin
                            r_ovr <= 1'b0;
                            // A trigger coinciding with the clear replaces the old event.
                            if (!w_trig[n]) begin
                                if (BLANK_CYC == 0) begin
                                    r_st <= StIdle;
                                end else begin
                                    r_st   <= StBlank;
                                    r_bcnt <= BLoad;
                                end
                            end
                        end else if (w_trig[n]) begin
                            r_ovr <= 1'b1;
                        end
                    end
                    StBlank: begin
                        if (clr_i[n]) r_ovr <= 1'b0;
                        if (r_bcnt == '0) r_st <= StIdle;
                        else r_bcnt <= r_bcnt - 1'b1;
                    end
                    default: r_st <= StIdle;
                endcase
            end
        end

        assign pend_o[n] = r_pend;
        assign ovr_o[n]  = r_ovr;

`ifdef EDGE_IRQ_CNT_EN
        logic [CW-1:0] r_cnt;

        always_ff @(posedge clk_i) begin
            if (rst_i || cnt_clr_i) begin
                r_cnt <= '0;
            end else if (w_trig[n] && (r_cnt != {CW{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign cnt_o[CW*n +: CW] = r_cnt;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_irq <= 1'b0;
        else r_irq <= |w_pend_nxt;
    end

    assign irq_o = r_irq;

endmodule

// File: tb/tb_edge_irq_ctrl.sv
// Directed self-checking bench for edge_irq_ctrl (NCH=8, BLANK_CYC=4, CW=4).
module tb_edge_irq_ctrl;

    localparam int unsigned NCH = 8;
    localparam int unsigned CW  = 4;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    re;
    logic [NCH-1:0]    fe;
    logic [2*NCH-1:0]  mode;
    logic [NCH-1:0]    clr;
    logic [NCH-1:0]    pend;
    logic [NCH-1:0]    ovr;
    logic              irq;
`ifdef EDGE_IRQ_CNT_EN
    logic              cnt_clr;
    logic [CW*NCH-1:0] cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    edge_irq_ctrl #(
        .NCH       (NCH),
        .BLANK_CYC (4),
        .CW        (CW)
    ) u_dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .re_i      (re),
        .fe_i      (fe),
        .mode_i    (mode),
        .clr_i     (clr),
        .pend_o    (pend),
        .ovr_o     (ovr),
`ifdef EDGE_IRQ_CNT_EN
        .cnt_clr_i (cnt_clr),
        .cnt_o     (cnt),
`endif
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Apply the currently driven inputs for one cycle, then drop the single-cycle pulses.
    task automatic step();
        @(posedge clk);
        #1;
        re  = '0;
        fe  = '0;
        clr = '0;
`ifdef EDGE_IRQ_CNT_EN
        cnt_clr = 1'b0;
`endif
    endtask

    initial begin
        rst  = 1'b1;
        re   = '1;
        fe   = '1;
        mode = '1;
        clr  = '0;
`ifdef EDGE_IRQ_CNT_EN
        cnt_clr = 1'b0;
`endif
        // 1. Reset with all edges asserted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_pend", pend, 0);
            check("rst_ovr", ovr, 0);
            check("rst_irq", irq, 0);
        end
        rst = 1'b0;
        re  = '0;
        fe  = '0;
        mode = '0;
        step();
        check("idle_pend", pend, 0);
        check("idle_irq", irq, 0);
`ifdef EDGE_IRQ_CNT_EN
        check("rst_cnt", cnt, 0);
`endif

        // 2. Mode qualification on ch0
        mode = 16'h0001;
        fe[0] = 1'b1;
        step();
        check("m01_fall_ign", pend[0], 0);
        re[0] = 1'b1;
        step();
        check("m01_rise_pend", pend[0], 1);
        check("m01_rise_irq", irq, 1);
        clr[0] = 1'b1;
        step();
        check("m01_clr", pend[0], 0);
        mode = 16'h0002;
        for (int i = 0; i < 6; i++) step();
        re[0] = 1'b1;
        step();
        check("m10_rise_ign", pend[0], 0);
        check("m10_rise_irq", irq, 0);
        fe[0] = 1'b1;
        step();
        check("m10_fall_pend", pend[0], 1);
        mode = 16'h0000;
        step();
        check("m00_drop_pend", pend[0], 0);
        check("m00_drop_irq", irq, 0);

        // 3. Overrun on ch2
        mode = 16'h0030;
        re[2] = 1'b1;
        step();
        check("ovr_first_pend", pend[2], 1);
        check("ovr_first_ovr", ovr[2], 0);
        re[2] = 1'b1;
        step();
        check("ovr_second_ovr", ovr[2], 1);
        check("ovr_second_pend", pend[2], 1);
        clr[2] = 1'b1;
        step();
        check("ovr_clr_pend", pend[2], 0);
        check("ovr_clr_ovr", ovr[2], 0);

        // 4. Blanking on ch1: clr in cycle c, pulses c+1..c+4 ignored, c+5 accepted
        mode = 16'h0004;
        re[1] = 1'b1;
        step();
        check("blk_pend_set", pend[1], 1);
        clr[1] = 1'b1;
        step();
        check("blk_clr", pend[1], 0);
        for (int k = 1; k <= 4; k++) begin
            re[1] = 1'b1;
            step();
            check($sformatf("blk_ign_c%0d", k), pend[1], 0);
        end
        check("blk_no_ovr", ovr[1], 0);
        re[1] = 1'b1;
        step();
        check("blk_accept_c5", pend[1], 1);

        // 5. Simultaneous events
        mode = 16'h0040;
        re[3] = 1'b1;
        step();
        re[3] = 1'b1;
        step();
        check("sim_pre_ovr", ovr[3], 1);
        re[3]  = 1'b1;
        clr[3] = 1'b1;
        step();
        check("sim_trigclr_pend", pend[3], 1);
        check("sim_trigclr_ovr", ovr[3], 0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_pend", pend, 0);
        mode = 16'h5555;
        re = 8'hFF;
        step();
        check("all_pend", pend, 8'hFF);
        check("all_irq", irq, 1);
        mode = 16'h5155;
        step();
        check("mode0_midpend", pend, 8'hDF);
        mode = 16'h0000;
        step();
        check("off_pend", pend, 0);
        check("off_ovr", ovr, 0);
        check("off_irq", irq, 0);

`ifdef EDGE_IRQ_CNT_EN
        // 6. Counter saturation and clear priority
        rst = 1'b1;
        step();
        rst = 1'b0;
        mode = 16'h0001;
        for (int i = 1; i <= 20; i++) begin
            re[0] = 1'b1;
            step();
            if (i == 1) check("cnt_first", cnt[3:0], 1);
            if (i == 15) check("cnt_15", cnt[3:0], 15);
        end
        check("cnt_sat", cnt[3:0], 15);
        check("cnt_other_ch", cnt[31:4], 0);
        re[0]   = 1'b1;
        cnt_clr = 1'b1;
        step();
        check("cnt_clr_wins", cnt[3:0], 0);
        re[0] = 1'b1;
        step();
        check("cnt_after_clr", cnt[3:0], 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
